// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_MIN_CPB = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an idle-high line; flops reset to 1.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ff <= '1;
        else         ff <= {ff[STAGES-2:0], d_i};
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: start validation, 3-sample mid-bit vote, stop/parity checks and a
// one-byte valid/ready holding register. Define UART_RX_PARITY_EN for the 11-bit parity frame.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CPB_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    input  logic                   rx_en_i,
    input  logic [CPB_W-1:0]       clks_per_bit_i,
`ifdef UART_RX_PARITY_EN
    input  logic                   parity_odd_i,
`endif
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   busy_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o,
    output logic                   overrun_o,
    output logic                   break_o
);

    uart_rx_state_e         state;
    logic                   rxs, rxs_q;
    logic [CPB_W-1:0]       cpb, cnt, mid;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic [1:0]             smp;
    logic                   at_vote, vote, start_det;
`ifdef UART_RX_PARITY_EN
    logic                   par_pend;
`endif

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (rxs)
    );

    assign mid     = cpb >> 1;
    assign at_vote = (cnt == mid + CPB_W'(1));
    // smp[0]/smp[1] hold the samples at mid-1 and mid; the live line supplies mid+1
    assign vote    = maj3(smp[0], smp[1], rxs);
    assign start_det = rxs_q & ~rxs & rx_en_i & ~break_o &
                       (clks_per_bit_i >= CPB_W'(UART_MIN_CPB));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rxs_q       <= 1'b1;
            cpb         <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            smp         <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            break_o     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend     <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            rxs_q       <= rxs;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            if (rxs) break_o <= 1'b0;

            if (state != IDLE) begin
                cnt <= (cnt == cpb - CPB_W'(1)) ? '0 : cnt + CPB_W'(1);
                if (cnt == mid - CPB_W'(1)) smp[0] <= rxs;
                if (cnt == mid)             smp[1] <= rxs;
            end

            if (state != IDLE && !rx_en_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_det) begin
                        state   <= START;
                        busy_o  <= 1'b1;
                        cpb     <= clks_per_bit_i;
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_pend <= 1'b0;
`endif
                    end
                    START: if (at_vote) begin
                        if (vote) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: if (at_vote) begin
                        shreg   <= {vote, shreg[UART_DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: if (at_vote) begin
                        par_pend <= (vote != (^shreg ^ parity_odd_i));
                        state    <= STOP;
                    end
`endif
                    // Leave at mid stop bit so the next start edge is caught early
                    STOP: if (at_vote) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        if (!vote) begin
                            frame_err_o <= 1'b1;
                            if (shreg == '0) break_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_pend) begin
                            parity_err_o <= 1'b1;
`endif
                        end else if (rx_valid_o && !rx_ready_i) begin
                            overrun_o <= 1'b1;
                        end else begin
                            rx_data_o  <= shreg;
                            rx_valid_o <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

endmodule
